fifo_rr_arbiter: RTL and testbench
==================================

FIFO_RR_ARBITER -- requirements
Module: fifo_rr_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requester FIFOs, range 2..16.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-003 SHALL have parameter READ_LATENCY, default 2, cycles from FIFO deq to valid FIFO q; range 1..4.
REQ-004 SHALL have port clock  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-006 SHALL have port i_empty  input  NUM_REQ  per-requester FIFO empty flag.
REQ-007 SHALL have port o_deq  output  NUM_REQ  per-requester FIFO dequeue strobe, at most one bit high.
REQ-008 SHALL have port i_data  input  NUM_REQ*DATA_WIDTH  concatenated FIFO q outputs, requester k at bits [k*DATA_WIDTH +: DATA_WIDTH].
REQ-009 SHALL have port i_almost_full  input  1  downstream stop; downstream still absorbs READY_LATENCY words.
REQ-010 SHALL have port i_flush  input  1  request to stop issuing and drain in-flight words.
REQ-011 SHALL have port o_data  output  DATA_WIDTH  merged output word.
REQ-012 SHALL have port o_valid  output  1  o_data qualifier.
REQ-013 SHALL have port o_src  output  $clog2(NUM_REQ)  requester index of o_data.
REQ-014 SHALL have port o_flush_done  output  1  high while drained and idle under flush.

Function
REQ-015 SHALL implement FSM states RUN, STALL, DRAIN, FLUSHED.
REQ-016 RUN: SHALL issue one o_deq per cycle to the first non-empty requester strictly after last_grant in cyclic order.
REQ-017 RUN->STALL when i_almost_full=1; STALL->RUN when i_almost_full=0; no o_deq in STALL.
REQ-018 Any state except FLUSHED ->DRAIN when i_flush=1; i_flush has priority over i_almost_full.
REQ-019 DRAIN: no o_deq; ->FLUSHED when in-flight count is 0.
REQ-020 FLUSHED: o_flush_done=1, no o_deq; ->RUN when i_flush=0.
REQ-021 o_deq SHALL be combinational from state, i_empty, i_almost_full, i_flush, last_grant; zero if all i_empty=1.
REQ-022 last_grant SHALL update only on a cycle with an o_deq bit high.
REQ-023 A deq at cycle t SHALL produce o_valid=1, o_src=k, o_data=i_data slice k at cycle t+READ_LATENCY.
REQ-024 in-flight tracking SHALL be a READ_LATENCY-deep shift register of {valid, src}; o_valid/o_src from its last stage, o_data a combinational mux by o_src.
REQ-025 in-flight count SHALL be 0..READ_LATENCY, +1 on deq, -1 on o_valid, unchanged when both occur.
REQ-026 Same requester SHALL be re-granted back-to-back only when it is the sole non-empty requester.
REQ-027 Deasserting i_flush in DRAIN SHALL not abort the drain; exit only via FLUSHED.

Reset
REQ-028 On reset=0: state=RUN, last_grant=NUM_REQ-1, shift register cleared, count=0.
REQ-029 During reset: o_deq=0, o_valid=0, o_src=0, o_flush_done=0; in-flight words SHALL be discarded.
REQ-030 Reset deassertion SHALL be synchronised externally; first grant after reset SHALL favour requester 0.

Structure
REQ-031 Package fifo_arb_pkg SHALL hold the state enum and the default parameter constants.
REQ-032 Sub-module rr_pick SHALL compute the one-hot round-robin grant from request vector and last_grant.

Verification
REQ-033 NUM_REQ=4, all non-empty, no stall -> o_deq order 0,1,2,3,0; o_src same order 2 cycles later.
REQ-034 Only requester 2 non-empty for 5 cycles -> o_deq[2] high 5 consecutive cycles, 5 o_valid with o_src=2.
REQ-035 i_almost_full=1 for cycles 10..14 -> no o_deq in 10..14; in-flight words still output; resume at 15 with next requester after last_grant.
REQ-036 i_flush at cycle 20 with 2 in flight -> no o_deq from 20; o_valid at 20,21; o_flush_done from 22 until i_flush=0.
REQ-037 reset=0 mid-stream with 2 in flight -> o_valid=0 immediately; after release first grant goes to requester 0.
REQ-038 All i_empty=1 -> o_deq=0 and o_valid=0 indefinitely; a later single non-empty requester granted the same cycle.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// ============================================================================
//  Module      : fifo_arb_pkg
//  Description : Shared types and default parameter values for the
//                round-robin FIFO merge arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package fifo_arb_pkg;

    localparam int NUM_REQ_DEFAULT      = 4;
    localparam int DATA_WIDTH_DEFAULT   = 32;
    localparam int READ_LATENCY_DEFAULT = 2;

    // Arbiter control states
    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_STALL   = 2'd1,
        ST_DRAIN   = 2'd2,
        ST_FLUSHED = 2'd3
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// ============================================================================
//  Module      : rr_pick
//  Description : One-hot round-robin grant. Picks the first requester
//                strictly after the previous grant, wrapping cyclically.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = NUM_REQ_DEFAULT,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last_grant,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [IDX_W-1:0]   o_grant_idx,
    output logic               o_any
);

    int               w_pos;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;

    assign o_any = |i_req;

    // Scan from last_grant+1 around the ring; the last candidate is last_grant itself
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_pos       = 0;
        w_idx       = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            w_pos = int'(i_last_grant) + off;
            if (w_pos >= NUM_REQ) begin
                w_pos = w_pos - NUM_REQ;
            end
            w_idx = IDX_W'(w_pos);
            if (!w_found && i_req[w_idx]) begin
                w_found         = 1'b1;
                o_grant[w_idx]  = 1'b1;
                o_grant_idx     = w_idx;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/fifo_rr_arbiter.sv
// ============================================================================
//  Module      : fifo_rr_arbiter
//  Description : Merges NUM_REQ read-latency FIFOs into one stream with a
//                round-robin dequeue, downstream back-pressure and a
//                flush/drain handshake.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ      = NUM_REQ_DEFAULT,
    parameter int DATA_WIDTH   = DATA_WIDTH_DEFAULT,
    parameter int READ_LATENCY = READ_LATENCY_DEFAULT
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            i_empty,
    output logic [NUM_REQ-1:0]            o_deq,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] i_data,
    input  logic                          i_almost_full,
    input  logic                          i_flush,
    output logic [DATA_WIDTH-1:0]         o_data,
    output logic                          o_valid,
    output logic [$clog2(NUM_REQ)-1:0]    o_src,
    output logic                          o_flush_done
);

    localparam int c_src_w = $clog2(NUM_REQ);
    localparam int c_cnt_w = $clog2(READ_LATENCY + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_src_w-1:0] c_last_idx = c_src_w'(NUM_REQ - 1);

    arb_state_t            r_state;
    logic                  r_flush_done;
    logic [c_src_w-1:0]    r_last_grant;
    logic [READ_LATENCY-1:0] r_pipe_vld;
    logic [c_src_w-1:0]    r_pipe_src [READ_LATENCY];
    logic [c_cnt_w-1:0]    r_count;

    logic [NUM_REQ-1:0]    w_grant;
    logic [c_src_w-1:0]    w_grant_idx;
    logic                  w_any;
    logic                  w_deq_en;
    logic                  w_deq_any;
    logic [c_cnt_w-1:0]    w_count_next;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (c_src_w)
    ) u_rr_pick (
        .i_req        (~i_empty),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant),
        .o_grant_idx  (w_grant_idx),
        .o_any        (w_any)
    );

    // Dequeue is permitted only while issuing (RUN, or STALL about to release)
    // and never while reset is held, so the strobe is quiet during reset.
    assign w_deq_en  = reset && !i_almost_full && !i_flush &&
                       ((r_state == ST_RUN) || (r_state == ST_STALL));
    assign o_deq     = w_deq_en ? w_grant : '0;
    assign w_deq_any = w_deq_en && w_any;

    // In-flight count: +1 on deq, -1 when a word emerges, unchanged on both
    always_comb begin
        w_count_next = r_count;
        case ({w_deq_any, o_valid})
            2'b10:   w_count_next = r_count + c_cnt_one;
            2'b01:   w_count_next = r_count - c_cnt_one;
            default: w_count_next = r_count;
        endcase
    end

    // Control FSM; flush_done asserts on entry to FLUSHED so it tracks the state
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_RUN;
            r_flush_done <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_flush) begin
                        r_state <= ST_DRAIN;
                    end else if (i_almost_full) begin
                        r_state <= ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (i_flush) begin
                        r_state <= ST_DRAIN;
                    end else if (!i_almost_full) begin
                        r_state <= ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    // Leave as soon as the last in-flight word is emerging,
                    // regardless of whether flush is still requested.
                    if (w_count_next == '0) begin
                        r_state      <= ST_FLUSHED;
                        r_flush_done <= 1'b1;
                    end
                end
                ST_FLUSHED: begin
                    if (!i_flush) begin
                        r_state      <= ST_RUN;
                        r_flush_done <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= ST_RUN;
                    r_flush_done <= 1'b0;
                end
            endcase
        end
    end

    // Round-robin pointer moves only when a dequeue actually happens
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_last_grant <= c_last_idx;
        end else if (w_deq_any) begin
            r_last_grant <= w_grant_idx;
        end
    end

    // In-flight shift register of {valid, src} plus occupancy counter
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_pipe_vld <= '0;
            r_count    <= '0;
            for (int i = 0; i < READ_LATENCY; i++) begin
                r_pipe_src[i] <= '0;
            end
        end else begin
            r_pipe_vld[0] <= w_deq_any;
            r_pipe_src[0] <= w_grant_idx;
            for (int i = 1; i < READ_LATENCY; i++) begin
                r_pipe_vld[i] <= r_pipe_vld[i-1];
                r_pipe_src[i] <= r_pipe_src[i-1];
            end
            r_count <= w_count_next;
        end
    end

    assign o_valid      = r_pipe_vld[READ_LATENCY-1];
    assign o_src        = r_pipe_src[READ_LATENCY-1];
    assign o_data       = i_data[int'(o_src)*DATA_WIDTH +: DATA_WIDTH];
    assign o_flush_done = r_flush_done;

endmodule

`default_nettype wire

// File: tb/tb_fifo_rr_arbiter.sv
// ============================================================================
//  Module      : tb_fifo_rr_arbiter
//  Description : Directed self-checking bench for fifo_rr_arbiter
//                (NUM_REQ=4, DATA_WIDTH=32, READ_LATENCY=2).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_rr_arbiter;

    logic         clock;
    logic         reset;
    logic [3:0]   i_empty;
    logic [3:0]   o_deq;
    logic [127:0] i_data;
    logic         i_almost_full;
    logic         i_flush;
    logic [31:0]  o_data;
    logic         o_valid;
    logic [1:0]   o_src;
    logic         o_flush_done;

    int n_vec = 0;
    int n_bad = 0;

    fifo_rr_arbiter #(
        .NUM_REQ      (4),
        .DATA_WIDTH   (32),
        .READ_LATENCY (2)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .i_empty       (i_empty),
        .o_deq         (o_deq),
        .i_data        (i_data),
        .i_almost_full (i_almost_full),
        .i_flush       (i_flush),
        .o_data        (o_data),
        .o_valid       (o_valid),
        .o_src         (o_src),
        .o_flush_done  (o_flush_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [31:0] word_of(input logic [1:0] k);
        return 32'hD000_0000 + 32'h1111 * {30'd0, k};
    endfunction

    task automatic idle(input int n);
        i_empty = 4'hF;
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic test_reset();
        i_empty = 4'h0;
        @(negedge clock);
        n_vec++; if (o_deq !== 4'h0) begin n_bad++; $display("FAIL reset_deq got %b exp 0000", o_deq); end
        n_vec++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b exp 0", o_valid); end
        n_vec++; if (o_src !== 2'd0) begin n_bad++; $display("FAIL reset_src got %0d exp 0", o_src); end
        n_vec++; if (o_flush_done !== 1'b0) begin n_bad++; $display("FAIL reset_flush_done got %b exp 0", o_flush_done); end
        @(posedge clock);
        #1;
        reset = 1'b1;
    endtask

    // all non-empty: deq 0,1,2,3,0,1,2; outputs two cycles later
    task automatic test_rr_order();
        logic [3:0] emp [9] = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'hF,4'hF};
        logic [3:0] edq [9] = '{4'h1,4'h2,4'h4,4'h8,4'h1,4'h2,4'h4,4'h0,4'h0};
        logic [1:0] esr [9] = '{2'd0,2'd0,2'd0,2'd1,2'd2,2'd3,2'd0,2'd1,2'd2};
        logic [8:0] evl = 9'b1_1111_1100;
        for (int t = 0; t < 9; t++) begin
            i_empty = emp[t];
            @(negedge clock);
            n_vec++; if (o_deq !== edq[t]) begin n_bad++; $display("FAIL rr_order_deq t=%0d got %b exp %b", t, o_deq, edq[t]); end
            n_vec++; if (o_valid !== evl[t]) begin n_bad++; $display("FAIL rr_order_valid t=%0d got %b exp %b", t, o_valid, evl[t]); end
            if (evl[t]) begin
                n_vec++; if (o_src !== esr[t]) begin n_bad++; $display("FAIL rr_order_src t=%0d got %0d exp %0d", t, o_src, esr[t]); end
                n_vec++; if (o_data !== word_of(esr[t])) begin n_bad++; $display("FAIL rr_order_data t=%0d got %h exp %h", t, o_data, word_of(esr[t])); end
            end
            @(posedge clock);
            #1;
        end
    endtask

    // only requester 2 non-empty: granted five cycles back-to-back
    task automatic test_back_to_back();
        logic [3:0] emp [7] = '{4'hB,4'hB,4'hB,4'hB,4'hB,4'hF,4'hF};
        logic [3:0] edq [7] = '{4'h4,4'h4,4'h4,4'h4,4'h4,4'h0,4'h0};
        logic [6:0] evl = 7'b111_1100;
        for (int t = 0; t < 7; t++) begin
            i_empty = emp[t];
            @(negedge clock);
            n_vec++; if (o_deq !== edq[t]) begin n_bad++; $display("FAIL b2b_deq t=%0d got %b exp %b", t, o_deq, edq[t]); end
            n_vec++; if (o_valid !== evl[t]) begin n_bad++; $display("FAIL b2b_valid t=%0d got %b exp %b", t, o_valid, evl[t]); end
            if (evl[t]) begin
                n_vec++; if (o_src !== 2'd2) begin n_bad++; $display("FAIL b2b_src t=%0d got %0d exp 2", t, o_src); end
                n_vec++; if (o_data !== word_of(2'd2)) begin n_bad++; $display("FAIL b2b_data t=%0d got %h exp %h", t, o_data, word_of(2'd2)); end
            end
            @(posedge clock);
            #1;
        end
    endtask

    // almost_full for three cycles; in-flight word still emerges; resume with 0
    task automatic test_stall();
        logic [3:0] emp [8] = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'hF,4'hF};
        logic [3:0] edq [8] = '{4'h8,4'h0,4'h0,4'h0,4'h1,4'h2,4'h0,4'h0};
        logic [1:0] esr [8] = '{2'd0,2'd0,2'd3,2'd0,2'd0,2'd0,2'd0,2'd1};
        logic [7:0] evl = 8'b1100_0100;
        logic [7:0] eaf = 8'b0000_1110;
        for (int t = 0; t < 8; t++) begin
            i_empty       = emp[t];
            i_almost_full = eaf[t];
            @(negedge clock);
            n_vec++; if (o_deq !== edq[t]) begin n_bad++; $display("FAIL stall_deq t=%0d got %b exp %b", t, o_deq, edq[t]); end
            n_vec++; if (o_valid !== evl[t]) begin n_bad++; $display("FAIL stall_valid t=%0d got %b exp %b", t, o_valid, evl[t]); end
            if (evl[t]) begin
                n_vec++; if (o_src !== esr[t]) begin n_bad++; $display("FAIL stall_src t=%0d got %0d exp %0d", t, o_src, esr[t]); end
            end
            @(posedge clock);
            #1;
        end
        i_almost_full = 1'b0;
    endtask

    // flush with two words in flight; done two cycles later until flush drops
    task automatic test_flush();
        logic [3:0] emp [10] = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'hF,4'hF};
        logic [3:0] edq [10] = '{4'h4,4'h8,4'h0,4'h0,4'h0,4'h0,4'h0,4'h1,4'h0,4'h0};
        logic [1:0] esr [10] = '{2'd0,2'd0,2'd2,2'd3,2'd0,2'd0,2'd0,2'd0,2'd0,2'd0};
        logic [9:0] evl = 10'b10_0000_1100;
        logic [9:0] efl = 10'b00_0011_1100;
        logic [9:0] edn = 10'b00_0111_0000;
        for (int t = 0; t < 10; t++) begin
            i_empty = emp[t];
            i_flush = efl[t];
            @(negedge clock);
            n_vec++; if (o_deq !== edq[t]) begin n_bad++; $display("FAIL flush_deq t=%0d got %b exp %b", t, o_deq, edq[t]); end
            n_vec++; if (o_valid !== evl[t]) begin n_bad++; $display("FAIL flush_valid t=%0d got %b exp %b", t, o_valid, evl[t]); end
            n_vec++; if (o_flush_done !== edn[t]) begin n_bad++; $display("FAIL flush_done t=%0d got %b exp %b", t, o_flush_done, edn[t]); end
            if (evl[t] && t < 4) begin
                n_vec++; if (o_src !== esr[t]) begin n_bad++; $display("FAIL flush_src t=%0d got %0d exp %0d", t, o_src, esr[t]); end
            end
            @(posedge clock);
            #1;
        end
        i_flush = 1'b0;
    endtask

    // reset asserted with two words in flight: outputs clear immediately
    task automatic test_reset_mid();
        i_empty = 4'h0;
        @(negedge clock);
        n_vec++; if (o_deq !== 4'h2) begin n_bad++; $display("FAIL rmid_deq0 got %b exp 0010", o_deq); end
        @(posedge clock);
        #1;
        @(negedge clock);
        n_vec++; if (o_deq !== 4'h4) begin n_bad++; $display("FAIL rmid_deq1 got %b exp 0100", o_deq); end
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        n_vec++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid got %b exp 0", o_valid); end
        n_vec++; if (o_deq !== 4'h0) begin n_bad++; $display("FAIL rmid_deq_in_reset got %b exp 0000", o_deq); end
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        n_vec++; if (o_deq !== 4'h1) begin n_bad++; $display("FAIL rmid_first_grant got %b exp 0001", o_deq); end
        n_vec++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid_after got %b exp 0", o_valid); end
        @(posedge clock);
        #1;
        i_empty = 4'hF;
        @(negedge clock);
        n_vec++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rmid_valid_gap got %b exp 0", o_valid); end
        @(posedge clock);
        #1;
        @(negedge clock);
        n_vec++; if (o_valid !== 1'b1 || o_src !== 2'd0) begin n_bad++; $display("FAIL rmid_out got valid=%b src=%0d exp valid=1 src=0", o_valid, o_src); end
        @(posedge clock);
        #1;
    endtask

    // all empty: nothing issued; a lone requester is granted the same cycle
    task automatic test_all_empty();
        logic [3:0] emp [9] = '{4'hF,4'hF,4'hF,4'hF,4'hF,4'h7,4'hF,4'hF,4'hF};
        logic [3:0] edq [9] = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h8,4'h0,4'h0,4'h0};
        logic [8:0] evl = 9'b0_1000_0000;
        for (int t = 0; t < 9; t++) begin
            i_empty = emp[t];
            @(negedge clock);
            n_vec++; if (o_deq !== edq[t]) begin n_bad++; $display("FAIL empty_deq t=%0d got %b exp %b", t, o_deq, edq[t]); end
            n_vec++; if (o_valid !== evl[t]) begin n_bad++; $display("FAIL empty_valid t=%0d got %b exp %b", t, o_valid, evl[t]); end
            if (evl[t]) begin
                n_vec++; if (o_src !== 2'd3) begin n_bad++; $display("FAIL empty_src t=%0d got %0d exp 3", t, o_src); end
                n_vec++; if (o_data !== word_of(2'd3)) begin n_bad++; $display("FAIL empty_data t=%0d got %h exp %h", t, o_data, word_of(2'd3)); end
            end
            @(posedge clock);
            #1;
        end
    endtask

    initial begin
        reset         = 1'b0;
        i_empty       = 4'hF;
        i_almost_full = 1'b0;
        i_flush       = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_data[k*32 +: 32] = word_of(2'(k));
        end
        @(posedge clock);
        @(posedge clock);
        #1;
        test_reset();
        test_rr_order();
        idle(2);
        test_back_to_back();
        idle(2);
        test_stall();
        idle(2);
        test_flush();
        idle(2);
        test_reset_mid();
        idle(2);
        test_all_empty();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
